sensor_scanner: RTL and testbench
=================================

Name: sensor_scanner

Overview:
- Sequential acquisition front end that produces the packed 5x8-bit temperature bus and 5-bit sensor-enable mask consumed by the temperature monitoring top.
- Polls each sensor in turn over a req/ack handshake and marks non-responding sensors absent after a timeout.
- Publishes a coherent snapshot of all sensors in one clock edge, so the downstream combinational averaging/alert path never sees a partially updated frame.

Parameters:
NR_SENSORS, 5, number of polled sensors; output widths scale with it
DATA_W, 8, temperature sample width per sensor
TIMEOUT, 15, cycles a request may stay asserted without ack before the sensor is marked absent (>=1)

Ports:
clk_i  input  1  single clock, rising edge
rst_i  input  1  asynchronous, active-high reset
start_i  input  1  begin a scan when sampled high in IDLE; ignored otherwise
sensor_req_o  output  NR_SENSORS  one-hot request to the sensor being polled
sensor_ack_i  input  1  shared ack from the polled sensor, qualified by sensor_req_o
sensor_data_i  input  DATA_W  shared sample bus, valid when sensor_ack_i is high
sensors_data_o  output  NR_SENSORS*DATA_W  published samples; sensor k at bits [k*DATA_W +: DATA_W]
sensors_en_o  output  NR_SENSORS  published presence mask; bit k = sensor k acked in the last scan
frame_valid_o  output  1  one-cycle pulse when a new snapshot is published
busy_o  output  1  high in every state except IDLE

Behaviour:
- One clock domain. rst_i is asynchronous and active-high: all state is cleared immediately, with no waiting for a clock edge.
- Reset values: sensor_req_o=0, sensors_data_o=0, sensors_en_o=0, frame_valid_o=0, busy_o=0, FSM=IDLE, index=0, timeout counter=0, shadow registers=0.
- FSM states: IDLE, REQ, GAP, PUBLISH.
  - IDLE: when start_i=1 at an edge, go to REQ with idx=0 and clear the shadow registers.
  - REQ: sensor_req_o = 1<<idx.
    - If sensor_ack_i=1 at an edge, capture sensor_data_i into shadow[idx], set shadow_en[idx]=1, go to GAP.
    - Otherwise, when the counter reaches TIMEOUT (TIMEOUT cycles in REQ with no ack), leave shadow[idx]=0 and shadow_en[idx]=0, go to GAP.
    - An ack on the TIMEOUT-th cycle counts as an ack (ack wins).
    - The counter clears on entry to REQ.
  - GAP: sensor_req_o=0 for exactly one cycle. Then, if idx=NR_SENSORS-1, go to PUBLISH; else idx+1 and go to REQ.
  - PUBLISH: copy shadow data and mask to sensors_data_o and sensors_en_o, assert frame_valid_o for the following cycle, go to IDLE.
- Published outputs change only on the PUBLISH edge (or on reset) and hold otherwise.
- Latency with all sensors acking immediately:
  - start sampled at edge 0; each sensor takes 2 edges (REQ, GAP).
  - PUBLISH is entered at edge 10; outputs update and frame_valid_o goes high after edge 11.
  - Worst case (all time out): 1 + NR_SENSORS*(TIMEOUT+1) + 1 edges.
- sensor_ack_i outside REQ (IDLE, GAP, PUBLISH) is ignored and has no side effects.
- start_i held high continuously gives back-to-back scans: IDLE samples it on the cycle frame_valid_o is high.
- Reset during a scan: the scan is abandoned and the published outputs clear to 0. No frame_valid_o pulse occurs for the aborted scan.
- Timeout counter width is $clog2(TIMEOUT+1) and it saturates, never wrapping.

Test Plan:
- Reset check: assert rst_i mid-cycle with no clock edge -> all outputs 0 immediately. Release, no start -> outputs remain 0, busy_o=0.
- Full scan, all sensors ack in the first REQ cycle with data 20,21,22,23,24 -> sensor_req_o walks 00001..10000 with one-cycle gaps. frame_valid_o pulses once, 11 edges after start. sensors_data_o=0x1817161514, sensors_en_o=5'b11111.
- Sensors 1 and 3 never ack, TIMEOUT=15 -> each of those requests is held 15 cycles and then dropped. sensors_en_o=5'b10101, and bytes 1 and 3 of sensors_data_o are 0x00.
- Sensor 2 acks on exactly its 15th REQ cycle with 0x30 -> captured: sensors_en_o[2]=1, byte 2 = 0x30. Sensor 2 acking on the 16th cycle -> absent.
- Spurious acks during IDLE/GAP with data 0xFF -> no capture and no state change. start_i pulsed while busy_o=1 -> ignored, exactly one frame_valid_o pulse.
- First scan publishes all 25; second scan starts, rst_i asserted at sensor 3 -> outputs 0 immediately and no frame_valid_o pulse. A new start afterwards completes normally.

Source files
------------

// File: rtl/sensor_scanner.sv
// Sequential sensor poller: walks a one-hot req/ack handshake over NR_SENSORS sensors,
// marks silent sensors absent after TIMEOUT cycles and publishes the whole frame in one edge.
module sensor_scanner #(
    parameter int NR_SENSORS = 5,
    parameter int DATA_W     = 8,
    parameter int TIMEOUT    = 15
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           start_i,
    output logic [NR_SENSORS-1:0]          sensor_req_o,
    input  logic                           sensor_ack_i,
    input  logic [DATA_W-1:0]              sensor_data_i,
    output logic [NR_SENSORS*DATA_W-1:0]   sensors_data_o,
    output logic [NR_SENSORS-1:0]          sensors_en_o,
    output logic                           frame_valid_o,
    output logic                           busy_o
);

    localparam int IDX_W = (NR_SENSORS > 1) ? $clog2(NR_SENSORS) : 1;
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NR_SENSORS - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_GAP,
        S_PUBLISH
    } state_e;

    state_e                         state_q, state_d;
    logic [IDX_W-1:0]               idx_q, idx_d;
    logic [CNT_W-1:0]               cnt_q, cnt_d, cnt_inc;
    logic [NR_SENSORS*DATA_W-1:0]   shadow_q, shadow_d;
    logic [NR_SENSORS-1:0]          shadow_en_q, shadow_en_d;
    logic [NR_SENSORS*DATA_W-1:0]   data_q, data_d;
    logic [NR_SENSORS-1:0]          en_q, en_d;
    logic                           fv_q, fv_d;

    // Saturating increment: the counter parks at TIMEOUT instead of wrapping.
    assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves one unassigned (no latches).
        state_d     = state_q;
        idx_d       = idx_q;
        cnt_d       = cnt_q;
        shadow_d    = shadow_q;
        shadow_en_d = shadow_en_q;
        data_d      = data_q;
        en_d        = en_q;
        fv_d        = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d     = S_REQ;
                    idx_d       = '0;
                    cnt_d       = '0;
                    shadow_d    = '0;
                    shadow_en_d = '0;
                end
            end
            S_REQ: begin
                // An ack on the final allowed cycle still wins over the timeout.
                if (sensor_ack_i) begin
                    shadow_d[idx_q*DATA_W +: DATA_W] = sensor_data_i;
                    shadow_en_d[idx_q]               = 1'b1;
                    state_d                          = S_GAP;
                    cnt_d                            = '0;
                end else if (cnt_inc == CNT_MAX) begin
                    state_d = S_GAP;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            S_GAP: begin
                cnt_d = '0;
                if (idx_q == LAST_IDX) begin
                    state_d = S_PUBLISH;
                end else begin
                    idx_d   = idx_q + IDX_W'(1);
                    state_d = S_REQ;
                end
            end
            S_PUBLISH: begin
                data_d  = shadow_q;
                en_d    = shadow_en_q;
                fv_d    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: the shadow frame is reset along with the control state so an aborted scan leaves nothing stale behind.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            cnt_q       <= '0;
            shadow_q    <= '0;
            shadow_en_q <= '0;
            data_q      <= '0;
            en_q        <= '0;
            fv_q        <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register updates from pre-edge values.
            state_q     <= state_d;
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            shadow_q    <= shadow_d;
            shadow_en_q <= shadow_en_d;
            data_q      <= data_d;
            en_q        <= en_d;
            fv_q        <= fv_d;
        end
    end

    assign sensor_req_o   = (state_q == S_REQ) ? (NR_SENSORS'(1) << idx_q) : '0;
    assign sensors_data_o = data_q;
    assign sensors_en_o   = en_q;
    assign frame_valid_o  = fv_q;
    assign busy_o         = (state_q != S_IDLE);

endmodule

// File: tb/tb_sensor_scanner.sv
// Self-checking bench for sensor_scanner: a behavioural sensor responder plus a timeline
// model of the scan (per-sensor request windows, gaps, publish) checked every cycle.
module tb_sensor_scanner;

    localparam int NR = 5;
    localparam int DW = 8;
    localparam int TO = 15;

    logic                 clk_i = 1'b0;
    logic                 rst_i;
    logic                 start_i;
    logic [NR-1:0]        sensor_req_o;
    logic                 sensor_ack_i;
    logic [DW-1:0]        sensor_data_i;
    logic [NR*DW-1:0]     sensors_data_o;
    logic [NR-1:0]        sensors_en_o;
    logic                 frame_valid_o;
    logic                 busy_o;

    sensor_scanner #(.NR_SENSORS(NR), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .start_i        (start_i),
        .sensor_req_o   (sensor_req_o),
        .sensor_ack_i   (sensor_ack_i),
        .sensor_data_i  (sensor_data_i),
        .sensors_data_o (sensors_data_o),
        .sensors_en_o   (sensors_en_o),
        .frame_valid_o  (frame_valid_o),
        .busy_o         (busy_o)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_errors = 0;

    // Sensor behaviour: ack on the cfg_delay-th request cycle (0 = never, TO+1 = one cycle too late).
    int            cfg_delay [NR];
    logic [DW-1:0] cfg_val   [NR];
    bit            spur_en;
    int            run_len   [NR];

    // Scan model: cycle c is the interval after posedge number c.
    int            cyc;
    bit            active;
    int            s_start;
    int            sdur [NR];
    logic [NR*DW-1:0] s_data, pub_data;
    logic [NR-1:0]    s_en, pub_en;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Expected outputs in cycle c from the scan timeline: each sensor holds req for its
    // duration, then one idle gap; after the last gap comes one publish cycle, then the new frame.
    function automatic void expect_at(input int c, output logic [NR-1:0] req, output logic busy,
                                      output logic fv, output logic [NR*DW-1:0] data,
                                      output logic [NR-1:0] en);
        int off;
        req  = '0;
        busy = 1'b0;
        fv   = 1'b0;
        data = pub_data;
        en   = pub_en;
        if (active && c >= s_start) begin
            off  = c - s_start;
            busy = 1'b1;
            for (int k = 0; k < NR; k++) begin
                if (off >= 0 && off < sdur[k]) req = NR'(1) << k;
                off -= sdur[k] + 1;
            end
            if (off >= 1) begin
                busy = 1'b0;
                fv   = (off == 1);
                data = s_data;
                en   = s_en;
            end
        end
    endfunction

    task automatic set_cfg_all(input int delay, input int base);
        for (int k = 0; k < NR; k++) begin
            cfg_delay[k] = delay;
            cfg_val[k]   = DW'(base + k);
        end
    endtask

    task automatic do_start(output int s);
        @(negedge clk_i);
        start_i = 1'b1;
        s = cyc + 1;
        @(negedge clk_i);
        start_i = 1'b0;
    endtask

    task automatic wait_frame(output int f);
        bit got;
        got = 1'b0;
        f = -1;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk_i);
            if (frame_valid_o === 1'b1) begin
                got = 1'b1;
                f = cyc;
                break;
            end
        end
        check("frame_seen", 64'(got), 64'(1));
    endtask

    initial begin
        int s, f, f2, n, r;
        bit found;
        rst_i = 1'b1;
        start_i = 1'b0;
        sensor_ack_i = 1'b0;
        sensor_data_i = '0;
        spur_en = 1'b0;
        cyc = 0;
        active = 1'b0;
        s_start = 0;
        s_data = '0;
        s_en = '0;
        pub_data = '0;
        pub_en = '0;
        set_cfg_all(1, 0);
        for (int k = 0; k < NR; k++) begin
            run_len[k] = 0;
            sdur[k] = 1;
        end

        fork
            begin : model
                logic [NR-1:0] mr, me;
                logic mb, mf;
                logic [NR*DW-1:0] md;
                forever begin
                    @(posedge clk_i or posedge rst_i);
                    if (clk_i) cyc++;
                    if (rst_i) begin
                        active = 1'b0;
                        pub_data = '0;
                        pub_en = '0;
                    end else if (start_i) begin
                        expect_at(cyc - 1, mr, mb, mf, md, me);
                        if (!mb) begin
                            if (active) begin
                                pub_data = s_data;
                                pub_en = s_en;
                            end
                            active = 1'b1;
                            s_start = cyc;
                            for (int k = 0; k < NR; k++) begin
                                bit present;
                                present = (cfg_delay[k] >= 1) && (cfg_delay[k] <= TO);
                                sdur[k] = present ? cfg_delay[k] : TO;
                                s_data[k*DW +: DW] = present ? cfg_val[k] : '0;
                                s_en[k] = present;
                            end
                        end
                    end
                end
            end
            begin : responder
                logic [NR-1:0] prev_r;
                int run, prev_k, k;
                prev_r = '0;
                run = 0;
                prev_k = 0;
                forever begin
                    @(negedge clk_i);
                    if (sensor_req_o != '0) begin
                        k = 0;
                        for (int i = 0; i < NR; i++) if (sensor_req_o[i]) k = i;
                        run = (sensor_req_o == prev_r) ? run + 1 : 1;
                        run_len[k] = run;
                        sensor_ack_i = (run == cfg_delay[k]);
                        sensor_data_i = sensor_ack_i ? cfg_val[k] : DW'($urandom);
                        prev_k = k;
                    end else begin
                        if (prev_r != '0 && run == TO && cfg_delay[prev_k] == TO + 1) begin
                            sensor_ack_i = 1'b1;
                            sensor_data_i = cfg_val[prev_k];
                        end else begin
                            sensor_ack_i = spur_en && ($urandom_range(0, 1) == 1);
                            sensor_data_i = 8'hFF;
                        end
                        run = 0;
                    end
                    prev_r = sensor_req_o;
                end
            end
            begin : compare
                logic [NR-1:0] er, ee;
                logic eb, ef;
                logic [NR*DW-1:0] ed;
                forever begin
                    @(negedge clk_i);
                    expect_at(cyc, er, eb, ef, ed, ee);
                    check("cyc_req",   64'(sensor_req_o),   64'(er));
                    check("cyc_busy",  64'(busy_o),         64'(eb));
                    check("cyc_fv",    64'(frame_valid_o),  64'(ef));
                    check("cyc_data",  64'(sensors_data_o), 64'(ed));
                    check("cyc_en",    64'(sensors_en_o),   64'(ee));
                end
            end
        join_none

        // Reset state
        #1;
        check("rst_data", 64'(sensors_data_o), 64'(0));
        check("rst_req",  64'(sensor_req_o),   64'(0));
        check("rst_fv",   64'(frame_valid_o),  64'(0));
        repeat (3) @(negedge clk_i);
        #1 rst_i = 1'b0;
        repeat (3) @(negedge clk_i);
        check("idle_busy", 64'(busy_o), 64'(0));
        check("idle_en",   64'(sensors_en_o), 64'(0));

        // Full scan, immediate acks, data 20..24
        set_cfg_all(1, 20);
        do_start(s);
        wait_frame(f);
        check("lat_full",  64'(f - s), 64'(11));
        check("data_full", 64'(sensors_data_o), 64'(40'h1817161514));
        check("en_full",   64'(sensors_en_o), 64'(5'b11111));

        // Sensors 1 and 3 never ack
        set_cfg_all(1, 8'h51);
        cfg_delay[1] = 0;
        cfg_delay[3] = 0;
        for (int k = 0; k < NR; k++) run_len[k] = 0;
        do_start(s);
        wait_frame(f);
        check("lat_to",   64'(f - s), 64'(39));
        check("en_to",    64'(sensors_en_o), 64'(5'b10101));
        check("byte1_to", 64'(sensors_data_o[15:8]),  64'(0));
        check("byte3_to", 64'(sensors_data_o[31:24]), 64'(0));
        check("hold1_to", 64'(run_len[1]), 64'(15));
        check("hold3_to", 64'(run_len[3]), 64'(15));

        // Ack on exactly the 15th request cycle, then on the 16th
        set_cfg_all(1, 8'h60);
        cfg_delay[2] = TO;
        cfg_val[2] = 8'h30;
        do_start(s);
        wait_frame(f);
        check("en2_last",   64'(sensors_en_o[2]), 64'(1));
        check("byte2_last", 64'(sensors_data_o[23:16]), 64'(8'h30));
        cfg_delay[2] = TO + 1;
        do_start(s);
        wait_frame(f);
        check("en_late",    64'(sensors_en_o), 64'(5'b11011));
        check("byte2_late", 64'(sensors_data_o[23:16]), 64'(0));

        // Spurious acks outside REQ and a start pulse while busy
        spur_en = 1'b1;
        set_cfg_all(2, 8'h70);
        do_start(s);
        repeat (4) @(negedge clk_i);
        start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        wait_frame(f);
        check("data_spur", 64'(sensors_data_o), 64'(40'h7473727170));
        n = 0;
        repeat (40) begin
            @(negedge clk_i);
            if (frame_valid_o) n++;
        end
        check("extra_frames", 64'(n), 64'(0));
        spur_en = 1'b0;

        // Reset in the middle of a second scan
        set_cfg_all(1, 8'h19);
        for (int k = 0; k < NR; k++) cfg_val[k] = 8'h19;
        do_start(s);
        wait_frame(f);
        check("data_25", 64'(sensors_data_o), 64'({5{8'h19}}));
        do_start(s);
        found = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk_i);
            if (sensor_req_o == 5'b01000) begin
                found = 1'b1;
                break;
            end
        end
        check("reach_s3", 64'(found), 64'(1));
        #2 rst_i = 1'b1;
        #1;
        check("abort_data", 64'(sensors_data_o), 64'(0));
        check("abort_en",   64'(sensors_en_o), 64'(0));
        check("abort_busy", 64'(busy_o), 64'(0));
        repeat (2) @(negedge clk_i);
        #1 rst_i = 1'b0;
        do_start(s);
        wait_frame(f);
        check("lat_after",  64'(f - s), 64'(11));
        check("en_after",   64'(sensors_en_o), 64'(5'b11111));

        // start_i held high: back-to-back scans
        @(negedge clk_i);
        start_i = 1'b1;
        s = cyc + 1;
        wait_frame(f);
        wait_frame(f2);
        start_i = 1'b0;
        check("b2b_first",  64'(f - s), 64'(11));
        check("b2b_period", 64'(f2 - f), 64'(12));

        // Randomised scans
        for (int it = 0; it < 25; it++) begin
            for (int k = 0; k < NR; k++) begin
                r = $urandom_range(0, 9);
                if (r < 6)       cfg_delay[k] = $urandom_range(1, 4);
                else if (r == 6) cfg_delay[k] = TO;
                else if (r == 7) cfg_delay[k] = TO + 1;
                else if (r == 8) cfg_delay[k] = 0;
                else             cfg_delay[k] = $urandom_range(5, TO - 1);
                cfg_val[k] = DW'($urandom);
            end
            spur_en = ($urandom_range(0, 1) == 1);
            do_start(s);
            if ($urandom_range(0, 1) == 1) begin
                repeat ($urandom_range(1, 6)) @(negedge clk_i);
                start_i = 1'b1;
                @(negedge clk_i);
                start_i = 1'b0;
            end
            wait_frame(f);
            repeat ($urandom_range(0, 3)) @(negedge clk_i);
        end
        spur_en = 1'b0;
        repeat (3) @(negedge clk_i);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
